// File: rtl/suma_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : suma_serial_ctrl
//  Description : Bit-serial addition controller. It drives one external 1-bit
//                full adder (suma) to add two WIDTH-bit operands LSB first,
//                one bit per clock, keeping the carry in a register between
//                cycles. It shifts the sum bits into a result register and
//                raises a one-cycle done pulse when the result is complete.
//
//  Ports       :
//      clk       - system clock, rising edge
//      rst       - asynchronous active-high reset
//      start     - operation request, sampled only while idle
//      a, b      - WIDTH-bit operands, latched when start is accepted
//      cin       - initial carry-in, latched when start is accepted
//      busy      - high while bits are being added
//      done      - one-cycle pulse; sum/cout valid from here on
//      sum       - registered WIDTH-bit result
//      cout      - registered final carry-out
//      add_a     - to full adder A
//      add_b     - to full adder B
//      add_cin   - to full adder Cin
//      add_s     - from full adder S
//      add_cout  - from full adder Cout
//
//  Revision    : 1.0 - initial release
// ============================================================================
module suma_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_s,
    input  logic             add_cout
);

    // Bit counter just wide enough to index WIDTH bits.
    localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_sa;
    logic [WIDTH-1:0]    r_sb;
    logic [WIDTH-1:0]    r_sum;
    logic                r_c;
    logic                r_cout;
    logic                r_busy;
    logic                r_done;
    logic [c_cnt_w-1:0]  r_cnt;

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers. busy/done are registered next to
    // the state so they are glitch-free and exactly track RUN/DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // sum/cout are left alone so the previous result
                        // stays readable until shifting begins.
                        r_sa    <= a;
                        r_sb    <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_c   <= add_cout;
                    // New bit enters at the MSB; after WIDTH shifts bit i
                    // has walked down to position i.
                    r_sum <= {add_s, r_sum[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_cout  <= add_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Always pass through IDLE before a new accept.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Full-adder drive. r_busy is high exactly in RUN, so gating with it
    // forces the adder inputs to 0 in IDLE/DONE and immediately on reset.
    // ------------------------------------------------------------------------
    assign add_a   = r_busy & r_sa[0];
    assign add_b   = r_busy & r_sb[0];
    assign add_cin = r_busy & r_c;

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_suma_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_suma_serial_ctrl
//  Description : Self-checking bench for suma_serial_ctrl. Two instances
//                (WIDTH=8 and WIDTH=3), each wired to a behavioural full
//                adder. Expected values come from plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_suma_serial_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- WIDTH = 8 instance ----------------
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8, add_a8, add_b8, add_cin8, add_s8, add_cout8;
    logic [7:0] sum8;

    assign add_s8    = add_a8 ^ add_b8 ^ add_cin8;
    assign add_cout8 = (add_a8 & add_b8) | (add_a8 & add_cin8) | (add_b8 & add_cin8);

    suma_serial_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
        .add_s(add_s8), .add_cout(add_cout8)
    );

    // ---------------- WIDTH = 3 instance ----------------
    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3, done3, cout3, add_a3, add_b3, add_cin3, add_s3, add_cout3;
    logic [2:0] sum3;

    assign add_s3    = add_a3 ^ add_b3 ^ add_cin3;
    assign add_cout3 = (add_a3 & add_b3) | (add_a3 & add_cin3) | (add_b3 & add_cin3);

    suma_serial_ctrl #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_s(add_s3), .add_cout(add_cout3)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Carry entering bit i of x + y + c: the carry out of the low i bits.
    function automatic logic carry_in(input logic [31:0] x, input logic [31:0] y,
                                      input logic c, input int i);
        logic [32:0] mask;
        logic [32:0] s;
        mask = (33'd1 << i) - 33'd1;
        s = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, c};
        return s[i];
    endfunction

    // One WIDTH=8 operation. Called at a negedge; returns at the negedge of
    // the IDLE cycle after DONE. glitch>=2 pulses start with other operands
    // during RUN; keep leaves start high throughout (back-to-back mode).
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input int glitch, input bit keep);
        logic [8:0] res;
        res = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc <= 8) begin
                chk("busy8_run", busy8, 1);
                chk("done8_run", done8, 0);
                chk("add_a8", add_a8, ta[cyc-1]);
                chk("add_b8", add_b8, tb[cyc-1]);
                chk("add_cin8", add_cin8, carry_in(32'(ta), 32'(tb), tc, cyc - 1));
            end else if (cyc == 9) begin
                chk("done8", done8, 1);
                chk("busy8_done", busy8, 0);
                chk("sum8", sum8, res[7:0]);
                chk("cout8", cout8, res[8]);
                chk("add8_done", {add_a8, add_b8, add_cin8}, 0);
            end else begin
                chk("done8_idle", done8, 0);
                chk("busy8_idle", busy8, 0);
                chk("sum8_hold", {cout8, sum8}, res);
                chk("add8_idle", {add_a8, add_b8, add_cin8}, 0);
            end
            if (cyc == 1) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                if (!keep) start8 = 1'b0;
            end
            if (!keep) begin
                if (cyc == glitch) begin
                    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
                end else if (cyc == glitch + 1) begin
                    start8 = 1'b0;
                end
            end
        end
    endtask

    // One WIDTH=3 operation, same timeline shape (done at cycle 4).
    task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tc);
        logic [3:0] res;
        res = {1'b0, ta} + {1'b0, tb} + {3'd0, tc};
        a3 = ta; b3 = tb; cin3 = tc; start3 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start3 = 1'b0;
            if (cyc <= 3) begin
                chk("busy3_run", busy3, 1);
                chk("add_cin3", add_cin3, carry_in(32'(ta), 32'(tb), tc, cyc - 1));
            end else if (cyc == 4) begin
                chk("done3", done3, 1);
                chk("res3", {cout3, sum3}, res);
                chk("add3_done", {add_a3, add_b3, add_cin3}, 0);
            end else begin
                chk("idle3", {busy3, done3}, 0);
                chk("add3_idle", {add_a3, add_b3, add_cin3}, 0);
            end
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_outs8", {busy8, done8, cout8, sum8, add_a8, add_b8, add_cin8}, 0);
        chk("rst_outs3", {busy3, done3, cout3, sum3, add_a3, add_b3, add_cin3}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle8_after_rst", {busy8, done8}, 0);

        // Directed cases
        op8(8'h5A, 8'h33, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 4, 1'b0);   // start pulse ignored in RUN
        op8(8'h00, 8'h00, 1'b0, 8, 1'b0);   // ignored on last RUN cycle

        // Async reset mid-operation, between edges
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {busy8, done8, cout8, sum8, add_a8, add_b8, add_cin8}, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {busy8, done8}, 0);
        end
        op8(8'h0F, 8'h01, 1'b0, 0, 1'b0);

        // Back-to-back with start held high
        for (int i = 0; i < 4; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1);
        start8 = 1'b0;
        @(negedge clk);

        // Randomized operations
        for (int i = 0; i < 24; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 9)), 1'($urandom_range(0, 3) == 0));
        start8 = 1'b0;

        // WIDTH=3 exhaustive
        for (int v = 0; v < 128; v++)
            op3(3'(v), 3'(v >> 3), 1'(v >> 6));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
